// File: rtl/blob_pkg.sv
// Shared definitions for the blob pixel streamer.
//   IMG_COL / IMG_ROW / FRAME_PIX : default frame geometry
//   PIX_CNT_W                     : width of the in/out pixel counters
//   state_t                       : streamer FSM states
package blob_pkg;

  localparam int IMG_COL   = 800;
  localparam int IMG_ROW   = 600;
  localparam int FRAME_PIX = IMG_COL * IMG_ROW;  // 480000
  localparam int PIX_CNT_W = 19;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SYNC,
    S_PREFILL,
    S_STREAM,
    S_WAIT
  } state_t;

endpackage

// File: rtl/blob_pixel_streamer_bit_fifo.sv
// bit_fifo: single-clock 1-bit FIFO feeding the streamer output.
//   i_clk, i_rst (sync, active high), i_flush (sync clear)
//   i_push/i_din  : write one bit (ignored when full)
//   i_pop         : read one bit (ignored when empty)
//   o_dout        : registered read data; 0 in any cycle after a cycle
//                   without a successful pop
//   o_full, o_empty, o_count : occupancy status
module bit_fifo #(
  parameter int DEPTH = 1024,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_flush,
  input  logic          i_push,
  input  logic          i_pop,
  input  logic          i_din,
  output logic          o_dout,
  output logic          o_full,
  output logic          o_empty,
  output logic [CW-1:0] o_count
);

  logic [DEPTH-1:0] r_mem;
  logic [AW-1:0]    r_wr;
  logic [AW-1:0]    r_rd;
  logic [CW-1:0]    r_count;
  logic             r_dout;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_full    = (r_count == CW'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign o_count   = r_count;
  assign o_dout    = r_dout;
  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop && !o_empty;

  // Storage carries no reset; occupancy is tracked by the pointers.
  always_ff @(posedge i_clk) begin
    if (w_do_push && !i_rst && !i_flush) begin
      r_mem[r_wr] <= i_din;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst || i_flush) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
      r_dout  <= 1'b0;
    end else begin
      if (w_do_push) r_wr <= r_wr + 1'b1;
      if (w_do_pop)  r_rd <= r_rd + 1'b1;
      // A failed or absent pop yields 0 so an underflow emits a zero bit.
      r_dout <= w_do_pop ? r_mem[r_rd] : 1'b0;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/blob_pixel_streamer.sv
// blob_pixel_streamer: thresholds a grayscale pixel stream to 1 bit per
// pixel, buffers the bits and emits exactly one frame, one bit per cycle,
// to the blob categorizer.
//   i_clk, i_rst           : clock, synchronous active-high reset
//   i_start                : frame request pulse (latches threshold/invert)
//   i_pix_valid/o_pix_ready/i_pix_data/i_pix_sof : source pixel handshake
//   i_threshold, i_invert  : binarisation controls
//   o_valid, o_seq         : frame-active and foreground bit to categorizer
//   i_consumer_req         : categorizer activity monitor
//   i_result_valid         : categorizer done, closes the frame
//   o_busy, o_underflow, o_frame_err : status / sticky error flags
//
// state     | meaning
// S_IDLE    | waiting for i_start
// S_SYNC    | discarding pixels until the start-of-frame pixel
// S_PREFILL | buffering bits until enough are queued to stream
// S_STREAM  | one bit popped per cycle, input still accepted
// S_WAIT    | frame sent, o_valid held until the result returns
module blob_pixel_streamer
  import blob_pkg::*;
#(
  parameter int IMG_COL    = blob_pkg::IMG_COL,
  parameter int IMG_ROW    = blob_pkg::IMG_ROW,
  parameter int PIX_W      = 8,
  parameter int FIFO_DEPTH = 1024,
  parameter int PREFILL    = 800
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic             i_pix_valid,
  output logic             o_pix_ready,
  input  logic [PIX_W-1:0] i_pix_data,
  input  logic             i_pix_sof,
  input  logic [PIX_W-1:0] i_threshold,
  input  logic             i_invert,
  output logic             o_valid,
  output logic             o_seq,
  input  logic             i_consumer_req,
  input  logic             i_result_valid,
  output logic             o_busy,
  output logic             o_underflow,
  output logic             o_frame_err
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam logic [PIX_CNT_W-1:0] FRAME_LEN   = PIX_CNT_W'(IMG_COL * IMG_ROW);
  localparam logic [CNT_W-1:0]     PREFILL_LVL = CNT_W'(PREFILL);

  state_t               r_state;
  logic [PIX_W-1:0]     r_thr;
  logic                 r_inv;
  logic [PIX_CNT_W-1:0] r_in_cnt;
  logic [PIX_CNT_W-1:0] r_out_cnt;
  logic                 r_valid;
  logic                 r_underflow;
  logic                 r_frame_err;

  logic                 w_accept_st;
  logic                 w_xfer;
  logic                 w_bit;
  logic                 w_push;
  logic                 w_pop;
  logic                 w_flush;
  logic                 w_fifo_dout;
  logic                 w_fifo_full;
  logic                 w_fifo_empty;
  logic [CNT_W-1:0]     w_fifo_count;

  assign w_accept_st = (r_state == S_SYNC) || (r_state == S_PREFILL) ||
                       (r_state == S_STREAM);
  assign o_pix_ready = w_accept_st && !w_fifo_full && (r_in_cnt < FRAME_LEN);
  assign w_xfer      = i_pix_valid && o_pix_ready;
  assign w_bit       = (i_pix_data >= r_thr) ^ r_inv;
  // In S_SYNC only the start-of-frame pixel enters the FIFO.
  assign w_push      = w_xfer && ((r_state != S_SYNC) || i_pix_sof);
  // Every S_STREAM cycle owes exactly one bit, buffered or not.
  assign w_pop       = (r_state == S_STREAM);
  assign w_flush     = (r_state == S_WAIT) && i_result_valid;

  bit_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_flush (w_flush),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_din   (w_bit),
    .o_dout  (w_fifo_dout),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty),
    .o_count (w_fifo_count)
  );

  assign o_valid     = r_valid;
  assign o_seq       = w_fifo_dout;
  assign o_busy      = (r_state != S_IDLE);
  assign o_underflow = r_underflow;
  assign o_frame_err = r_frame_err;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= S_IDLE;
      r_thr       <= '0;
      r_inv       <= 1'b0;
      r_in_cnt    <= '0;
      r_out_cnt   <= '0;
      r_valid     <= 1'b0;
      r_underflow <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_thr       <= i_threshold;
            r_inv       <= i_invert;
            r_in_cnt    <= '0;
            r_out_cnt   <= '0;
            r_underflow <= 1'b0;
            r_frame_err <= 1'b0;
            r_state     <= S_SYNC;
          end
        end
        S_SYNC: begin
          if (w_push) begin
            r_in_cnt <= PIX_CNT_W'(1);
            r_state  <= S_PREFILL;
          end
        end
        S_PREFILL: begin
          if (w_xfer) begin
            r_in_cnt <= r_in_cnt + 1'b1;
            if (i_pix_sof) r_frame_err <= 1'b1;
          end
          // A frame shorter than the prefill level starts once fully read.
          if ((w_fifo_count >= PREFILL_LVL) || (r_in_cnt == FRAME_LEN)) begin
            r_valid <= 1'b1;
            r_state <= S_STREAM;
          end
        end
        S_STREAM: begin
          if (w_xfer) r_in_cnt <= r_in_cnt + 1'b1;
          r_out_cnt <= r_out_cnt + 1'b1;
          if (w_fifo_empty) r_underflow <= 1'b1;
          // Consumer has had two cycles to react to o_valid by now.
          if (!i_consumer_req && (r_out_cnt >= PIX_CNT_W'(2))) r_frame_err <= 1'b1;
          if (r_out_cnt == FRAME_LEN - 1'b1) r_state <= S_WAIT;
        end
        S_WAIT: begin
          if (i_result_valid) begin
            r_valid <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/blob_pixel_streamer.md
Name: blob_pixel_streamer

Overview:
- Producer side of the binary pixel stream that the blob-categorizer consumes.
- Accepts a grayscale pixel stream from the frame-buffer read path with a valid/ready handshake.
- Thresholds each pixel to 1 bit, buffers the bits in a FIFO, and emits exactly one frame of IMG_COL*IMG_ROW bits, one bit per cycle, with no stalls, on o_valid/o_seq.
- Holds o_valid high until the categorizer returns its result-valid, then returns to idle.

Parameters:
- IMG_COL, 800, pixels per row.
- IMG_ROW, 600, rows per frame.
- PIX_W, 8, grayscale input width.
- FIFO_DEPTH, 1024, bit-FIFO entries (power of 2).
- PREFILL, 800, FIFO occupancy required before streaming starts.

Ports:
- i_clk, input, 1, clock.
- i_rst, input, 1, synchronous active-high reset.
- i_start, input, 1, one-cycle pulse requesting a frame.
- i_pix_valid, input, 1, source pixel valid.
- o_pix_ready, output, 1, source may transfer this cycle.
- i_pix_data, input, PIX_W, grayscale pixel.
- i_pix_sof, input, 1, marks first pixel of a frame.
- i_threshold, input, PIX_W, binarisation threshold.
- i_invert, input, 1, 1 = dark pixels are foreground.
- o_valid, output, 1, frame active (drives categorizer i_valid).
- o_seq, output, 1, foreground bit (drives categorizer i_seq).
- i_consumer_req, input, 1, categorizer SDRAM request (monitor only).
- i_result_valid, input, 1, categorizer result valid.
- o_busy, output, 1, state != S_IDLE.
- o_underflow, output, 1, sticky: FIFO empty while a bit was owed.
- o_frame_err, output, 1, sticky: SOF protocol violation.

Behaviour:
- Clocking and reset: one clock domain (i_clk). Reset is synchronous and active-high on i_rst.
- Reset values: all outputs 0, state S_IDLE, FIFO empty, counters 0. Reset mid-frame aborts immediately and flushes the FIFO.
- Input transfer: a transfer occurs when i_pix_valid && o_pix_ready.
- Bit computation: bit = (i_pix_data >= thr_q) XOR inv_q. thr_q and inv_q are i_threshold/i_invert latched on the i_start cycle, constant for the frame.
- o_pix_ready = (state in S_SYNC, S_PREFILL, S_STREAM) && !fifo_full && (in_cnt < IMG_COL*IMG_ROW).
- in_cnt and out_cnt are 19-bit; 480000 fits.
- S_IDLE:
  - o_valid=0, o_seq=0.
  - On i_start: latch thr/inv, clear in_cnt, out_cnt, o_underflow, o_frame_err, go to S_SYNC.
  - i_start in any other state is ignored.
- S_SYNC:
  - Transfers without i_pix_sof are discarded.
  - A transfer with i_pix_sof is pushed (in_cnt=1) and the state moves to S_PREFILL.
- S_PREFILL:
  - Push on every transfer.
  - If a transfer carries i_pix_sof, set o_frame_err; the pixel is still counted as data.
  - When occupancy >= PREFILL, or in_cnt reaches the frame size, assert o_valid next cycle and go to S_STREAM. Call the first o_valid=1 cycle T0.
- S_STREAM:
  - Bit k of the frame is on o_seq during cycle T0+1+k, for k = 0..IMG_COL*IMG_ROW-1. This matches the consumer entering its processing state one cycle after seeing i_valid.
  - One pop per cycle from T0+1 onward; o_seq is registered FIFO output.
  - If the FIFO is empty when a bit is owed: o_seq=0, set o_underflow, out_cnt still increments (frame length is never stretched).
  - Input pushes continue concurrently. Simultaneous push+pop keeps occupancy unchanged.
  - Pixels beyond the frame size are not accepted (o_pix_ready=0).
  - In cycles >= T0+2, i_consumer_req=0 sets o_frame_err.
  - After the last bit, go to S_WAIT with o_seq=0.
- S_WAIT:
  - o_valid stays 1, o_seq=0.
  - The cycle after i_result_valid=1 is seen, deassert o_valid, flush the FIFO, go to S_IDLE.
  - i_result_valid seen in S_STREAM is ignored.
- Sticky flags: cleared only by reset or the next accepted i_start.

Decomposition:
- Package blob_pkg:
  - IMG_COL, IMG_ROW, FRAME_PIX = 480000.
  - PIX_CNT_W = 19.
  - state enum {S_IDLE, S_SYNC, S_PREFILL, S_STREAM, S_WAIT}.
- Sub-module bit_fifo:
  - Synchronous FIFO, width 1, depth FIFO_DEPTH.
  - Ports push, pop, din, dout, full, empty, count.
  - Registered dout; same-cycle push+pop allowed when non-empty.

Test Plan:
- Threshold: i_threshold=128, i_invert=0, reduced frame 8x4 (IMG_COL=8, IMG_ROW=4, PREFILL=8), pixels alternating 200/50 -> o_seq 1,0,1,0... from T0+1, exactly 32 bits, then o_seq=0 held with o_valid=1.
- Invert: same frame with i_invert=1 -> complementary pattern; i_threshold changed mid-frame has no effect.
- SOF sync: 5 pixels without SOF precede the SOF pixel -> those 5 are dropped; first o_seq bit equals the SOF pixel's bit; o_frame_err=0.
- Starved source: i_pix_valid held 0 after 10 pixels of a 32-pixel frame -> o_underflow=1, zeros emitted, o_valid still covers exactly 32 bit-cycles.
- Handshake close: i_result_valid pulsed 3 cycles into S_WAIT -> o_valid low one cycle later, o_busy=0; a new i_start runs a second frame correctly.
- Reset: i_rst asserted at bit 15 -> next cycle all outputs 0, FIFO empty; a subsequent frame streams correctly.
